// File: rtl/cvxif_copro_router.sv
// cvxif_copro_router: routes one CV-X-IF core port to NrCopro coprocessor channels
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   issue_*                      core issue request/response, routed by custom opcode
//   reg_*                        core register operands, routed by ID table lookup
//   commit_*                     core commit/kill, forwarded to the owning channel
//   result_*                     arbitrated result stream back to the core
//   cp_*                         per-channel mirrored interfaces, flattened by NrCopro
module cvxif_copro_router #(
    parameter int NrCopro        = 2,
    parameter int IdWidth        = 3,
    parameter int XLEN           = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_valid_i,
    input  logic [31:0]                issue_instr_i,
    input  logic [IdWidth-1:0]         issue_id_i,
    output logic                       issue_ready_o,
    output logic                       issue_accept_o,
    output logic                       issue_writeback_o,
    input  logic                       reg_valid_i,
    input  logic [IdWidth-1:0]         reg_id_i,
    input  logic [2*XLEN-1:0]          reg_rs_i,
    output logic                       reg_ready_o,
    input  logic                       commit_valid_i,
    input  logic [IdWidth-1:0]         commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       result_valid_o,
    output logic [IdWidth-1:0]         result_id_o,
    output logic [XLEN-1:0]            result_data_o,
    output logic                       result_we_o,
    input  logic                       result_ready_i,
    output logic [NrCopro-1:0]         cp_issue_valid_o,
    output logic [NrCopro*32-1:0]      cp_issue_instr_o,
    output logic [NrCopro*IdWidth-1:0] cp_issue_id_o,
    input  logic [NrCopro-1:0]         cp_issue_ready_i,
    input  logic [NrCopro-1:0]         cp_issue_accept_i,
    input  logic [NrCopro-1:0]         cp_issue_writeback_i,
    output logic [NrCopro-1:0]         cp_reg_valid_o,
    output logic [NrCopro*IdWidth-1:0] cp_reg_id_o,
    output logic [NrCopro*2*XLEN-1:0]  cp_reg_rs_o,
    input  logic [NrCopro-1:0]         cp_reg_ready_i,
    output logic [NrCopro-1:0]         cp_commit_valid_o,
    output logic [NrCopro*IdWidth-1:0] cp_commit_id_o,
    output logic [NrCopro-1:0]         cp_commit_kill_o,
    input  logic [NrCopro-1:0]         cp_result_valid_i,
    input  logic [NrCopro*IdWidth-1:0] cp_result_id_i,
    input  logic [NrCopro*XLEN-1:0]    cp_result_data_i,
    input  logic [NrCopro-1:0]         cp_result_we_i,
    output logic [NrCopro-1:0]         cp_result_ready_o
);
    localparam int NrIds = 2**IdWidth;
    localparam int ChW   = (NrCopro > 1) ? $clog2(NrCopro) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);

    logic [NrIds-1:0] r_busy;
    logic [NrIds-1:0] r_we;
    logic [ChW-1:0]   r_ch [NrIds];
    logic [CntW-1:0]  r_cnt [NrCopro];
    logic [ChW-1:0]   r_ptr;
    logic [ChW-1:0]   r_lock_ch;
    logic             r_lock;

    logic [1:0]       w_ch;
    logic             w_route;
    logic             w_ok;
    logic [CntW-1:0]  w_cnt_sel;
    logic             w_iss_rdy;
    logic             w_iss_acc;
    logic             w_iss_wb;
    logic             w_alloc;
    logic             w_cm_busy;
    logic             w_kill_fr;
    logic             w_res_fr;
    logic             w_rhs;
    logic             w_any;
    logic             w_res_we;
    logic [ChW-1:0]   w_win;
    logic [ChW-1:0]   w_ptr_nxt;
    logic [NrIds-1:0] w_free;
    logic [NrIds-1:0] w_set;
    logic [CntW-1:0]  w_cnt_nxt [NrCopro];

    assign cp_issue_instr_o = {NrCopro{issue_instr_i}};
    assign cp_issue_id_o    = {NrCopro{issue_id_i}};
    assign cp_reg_id_o      = {NrCopro{reg_id_i}};
    assign cp_reg_rs_o      = {NrCopro{reg_rs_i}};
    assign cp_commit_id_o   = {NrCopro{commit_id_i}};

    // Issue: decode the custom opcode and gate on channel capacity and ID availability.
    always_comb begin
        w_ch      = issue_instr_i[6:5];
        w_route   = issue_instr_i[4:0] == 5'b01011 && 32'(w_ch) < NrCopro;
        w_cnt_sel = '0;
        w_iss_rdy = 1'b0;
        w_iss_acc = 1'b0;
        w_iss_wb  = 1'b0;
        for (int c = 0; c < NrCopro; c++) begin
            if (32'(w_ch) == c) begin
                w_cnt_sel = r_cnt[c];
                w_iss_rdy = cp_issue_ready_i[c];
                w_iss_acc = cp_issue_accept_i[c];
                w_iss_wb  = cp_issue_writeback_i[c];
            end
        end
        // A busy entry cannot be reallocated, which also covers an entry being freed this cycle.
        w_ok              = w_route && 32'(w_cnt_sel) < MaxOutstanding && !r_busy[issue_id_i];
        issue_ready_o     = w_route ? (w_ok && w_iss_rdy) : 1'b1;
        issue_accept_o    = !rst_i && w_ok && w_iss_acc;
        issue_writeback_o = !rst_i && w_ok && w_iss_wb;
        for (int c = 0; c < NrCopro; c++)
            cp_issue_valid_o[c] = !rst_i && issue_valid_i && w_ok && 32'(w_ch) == c;
        w_alloc = issue_valid_i && issue_ready_o && issue_accept_o;
    end

    // Register and commit: steered by the channel recorded for the ID.
    always_comb begin
        reg_ready_o = 1'b1;
        w_cm_busy   = commit_valid_i && r_busy[commit_id_i];
        w_kill_fr   = w_cm_busy && commit_kill_i;
        for (int c = 0; c < NrCopro; c++) begin
            cp_reg_valid_o[c]    = !rst_i && reg_valid_i && r_busy[reg_id_i] && 32'(r_ch[reg_id_i]) == c;
            cp_commit_valid_o[c] = !rst_i && w_cm_busy && 32'(r_ch[commit_id_i]) == c;
            cp_commit_kill_o[c]  = cp_commit_valid_o[c] && commit_kill_i;
            if (r_busy[reg_id_i] && 32'(r_ch[reg_id_i]) == c)
                reg_ready_o = cp_reg_ready_i[c];
        end
    end

    // Result arbitration: round-robin from r_ptr, held on the locked winner while stalled.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int k = NrCopro - 1; k >= 0; k--) begin
            for (int c = 0; c < NrCopro; c++) begin
                if (cp_result_valid_i[c] && (int'(r_ptr) + k == c || int'(r_ptr) + k == c + NrCopro)) begin
                    w_win = ChW'(c);
                    w_any = 1'b1;
                end
            end
        end
        for (int c = 0; c < NrCopro; c++) begin
            if (r_lock && 32'(r_lock_ch) == c && cp_result_valid_i[c]) begin
                w_win = ChW'(c);
                w_any = 1'b1;
            end
        end
        result_valid_o = !rst_i && w_any;
        result_id_o    = '0;
        result_data_o  = '0;
        w_res_we       = 1'b0;
        for (int c = 0; c < NrCopro; c++) begin
            cp_result_ready_o[c] = result_valid_o && result_ready_i && 32'(w_win) == c;
            if (32'(w_win) == c) begin
                result_id_o   = cp_result_id_i[c*IdWidth +: IdWidth];
                result_data_o = cp_result_data_i[c*XLEN +: XLEN];
                w_res_we      = cp_result_we_i[c];
            end
        end
        w_rhs     = result_valid_o && result_ready_i;
        w_ptr_nxt = (32'(w_win) == NrCopro - 1) ? '0 : w_win + ChW'(1);
    end

    // Results only write back when the instruction was accepted with writeback.
    assign result_we_o = w_res_we && r_we[result_id_o];

    // Frees and net count update; a kill and a result for the same ID decrement once.
    always_comb begin
        w_res_fr = w_rhs && r_busy[result_id_o] && !(w_kill_fr && result_id_o == commit_id_i);
        w_free   = '0;
        w_set    = '0;
        if (w_kill_fr)
            w_free[commit_id_i] = 1'b1;
        if (w_res_fr)
            w_free[result_id_o] = 1'b1;
        if (w_alloc)
            w_set[issue_id_i] = 1'b1;
        for (int c = 0; c < NrCopro; c++)
            w_cnt_nxt[c] = r_cnt[c] + CntW'(w_alloc && 32'(w_ch) == c)
                         - CntW'(w_kill_fr && 32'(r_ch[commit_id_i]) == c)
                         - CntW'(w_res_fr && 32'(r_ch[result_id_o]) == c);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy    <= '0;
            r_we      <= '0;
            r_ptr     <= '0;
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
            for (int i = 0; i < NrIds; i++)
                r_ch[i] <= '0;
            for (int c = 0; c < NrCopro; c++)
                r_cnt[c] <= '0;
        end else begin
            r_busy <= (r_busy & ~w_free) | w_set;
            if (w_alloc) begin
                r_ch[issue_id_i] <= ChW'(w_ch);
                r_we[issue_id_i] <= issue_writeback_o;
            end
            for (int c = 0; c < NrCopro; c++)
                r_cnt[c] <= w_cnt_nxt[c];
            if (w_rhs)
                r_ptr <= w_ptr_nxt;
            r_lock    <= result_valid_o && !result_ready_i;
            r_lock_ch <= w_win;
        end
    end
endmodule
